// File: rtl/fpga_top_pkg.sv
// rtl/fpga_top_pkg.sv - shared types and SPI command constants for the SPI-memory readout top
package fpga_top_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PWRUP,
      CMD,
      ADDR,
      READ,
      CSOFF,
      TX
   } state_t;

   localparam logic [7:0]  SPI_CMD_READ = 8'h03;
   localparam logic [23:0] SPI_ADDR     = 24'h000000;
   localparam int          CMD_BITS     = 8;
   localparam int          HDR_BITS     = 32;

endpackage

// File: rtl/fpga_top_if.sv
// rtl/fpga_top_if.sv - SPI memory bus including the memory power enable
interface fpga_top_if;
   logic MEM_VCC;
   logic SPI_CLK;
   logic SPI_MOSI;
   logic SPI_MISO;
   logic SPI_CS_n;

   modport master (output MEM_VCC, output SPI_CLK, output SPI_MOSI, output SPI_CS_n, input SPI_MISO);
   modport slave  (input MEM_VCC, input SPI_CLK, input SPI_MOSI, input SPI_CS_n, output SPI_MISO);
endinterface

// File: rtl/fpga_top_fifo.sv
// rtl/fpga_top_fifo.sv - synchronous FIFO with wrap-bit pointers and show-ahead read data
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_en && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !full)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end
endmodule

// File: rtl/fpga_top_uart.sv
// rtl/fpga_top_uart.sv - 8N1 UART transmitter, LSB first, idle high
module uart_tx #(
   parameter int UART_DIV = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       tx
);
   localparam int DW = $clog2(UART_DIV);

   logic [DW-1:0] div;
   logic [3:0]    nbit;
   logic [8:0]    sh;

   // nbit counts completed bit slots; sh carries the stop bit above the data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         tx   <= 1'b1;
         div  <= '0;
         nbit <= '0;
         sh   <= '0;
      end else if (start && !busy) begin
         busy <= 1'b1;
         tx   <= 1'b0;
         div  <= '0;
         nbit <= '0;
         sh   <= {1'b1, data};
      end else if (busy) begin
         if (div == DW'(UART_DIV - 1)) begin
            div <= '0;
            if (nbit == 4'd9) begin
               busy <= 1'b0;
            end else begin
               nbit <= nbit + 1'b1;
               tx   <= sh[0];
               sh   <= {1'b0, sh[8:1]};
            end
         end else begin
            div <= div + 1'b1;
         end
      end
   end
endmodule

// File: rtl/fpga_top.sv
// rtl/fpga_top.sv - push-button triggered SPI memory READ captured into a FIFO and drained over UART
module fpga_top
   import fpga_top_pkg::*;
#(
   parameter int SPI_HALF   = 2,
   parameter int UART_DIV   = 20,
   parameter int PWRUP_CYC  = 200,
   parameter int DEBOUNCE   = 4,
   parameter int READ_BYTES = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       CLKA,
   input  logic       rst,
   input  logic       pb_sw1,
   fpga_top_if.master spi,
   input  logic       UART_RX,
   output logic       UART_TX,
   output logic       FIFO_TRIG_WR,
   output logic       FIFO_TRIG_DL
);
   localparam int TOTAL_BITS = HDR_BITS + READ_BYTES * 8;
   localparam int BW         = $clog2(TOTAL_BITS + 1);
   localparam int PH_W       = $clog2(2 * SPI_HALF);
   localparam int PW_W       = $clog2(PWRUP_CYC + 1);
   localparam int DB_W       = $clog2(DEBOUNCE + 1);

   logic [1:0]      pb_sync;
   logic [1:0]      unused_uart_rx_s;
   logic            pb_armed;
   logic [DB_W-1:0] db_cnt;
   logic            press;

   state_t          state;
   logic [PW_W-1:0] pw_cnt;
   logic [PH_W-1:0] ph;
   logic [BW-1:0]   bit_cnt;
   logic [31:0]     tx_sh;
   logic [7:0]      rx_sh;
   logic [2:0]      rx_cnt;
   logic            push;
   logic            pop;

   logic [7:0]      fifo_rd_data;
   logic            fifo_empty;
   logic            uart_busy;

   // One start event per press: re-armed only after the button is seen released
   assign press = pb_armed && !pb_sync[1] && (db_cnt == DB_W'(DEBOUNCE - 1));

   always_ff @(posedge CLKA or posedge rst) begin
      if (rst) begin
         pb_sync          <= 2'b11;
         unused_uart_rx_s <= 2'b11;
         pb_armed         <= 1'b0;
         db_cnt           <= '0;
      end else begin
         pb_sync          <= {pb_sync[0], pb_sw1};
         unused_uart_rx_s <= {unused_uart_rx_s[0], UART_RX};
         if (pb_sync[1]) begin
            pb_armed <= 1'b1;
            db_cnt   <= '0;
         end else if (press) begin
            pb_armed <= 1'b0;
            db_cnt   <= '0;
         end else if (pb_armed) begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLKA or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pw_cnt       <= '0;
         ph           <= '0;
         bit_cnt      <= '0;
         tx_sh        <= '0;
         rx_sh        <= '0;
         rx_cnt       <= '0;
         push         <= 1'b0;
         pop          <= 1'b0;
         spi.MEM_VCC  <= 1'b0;
         spi.SPI_CLK  <= 1'b0;
         spi.SPI_MOSI <= 1'b0;
         spi.SPI_CS_n <= 1'b1;
      end else begin
         push <= 1'b0;
         pop  <= 1'b0;
         case (state)
            IDLE: begin
               if (press) begin
                  state       <= PWRUP;
                  spi.MEM_VCC <= 1'b1;
                  pw_cnt      <= '0;
               end
            end
            PWRUP: begin
               if (pw_cnt == PW_W'(PWRUP_CYC - 1)) begin
                  state        <= CMD;
                  spi.SPI_CS_n <= 1'b0;
                  tx_sh        <= {SPI_CMD_READ, SPI_ADDR};
                  spi.SPI_MOSI <= SPI_CMD_READ[7];
                  ph           <= '0;
                  bit_cnt      <= '0;
                  rx_cnt       <= '0;
               end else begin
                  pw_cnt <= pw_cnt + 1'b1;
               end
            end
            CMD, ADDR, READ: begin
               ph <= ph + 1'b1;
               if (ph == PH_W'(SPI_HALF - 1)) begin
                  spi.SPI_CLK <= 1'b1;
                  if (state == READ) begin
                     rx_sh  <= {rx_sh[6:0], spi.SPI_MISO};
                     rx_cnt <= rx_cnt + 1'b1;
                     push   <= (rx_cnt == 3'd7);
                  end
               end
               // Bit boundary: falling SCK and next MOSI bit launched together
               if (ph == PH_W'(2 * SPI_HALF - 1)) begin
                  spi.SPI_CLK  <= 1'b0;
                  ph           <= '0;
                  bit_cnt      <= bit_cnt + 1'b1;
                  tx_sh        <= {tx_sh[30:0], 1'b0};
                  spi.SPI_MOSI <= tx_sh[30];
                  if (bit_cnt == BW'(CMD_BITS - 1)) begin
                     state <= ADDR;
                  end else if (bit_cnt == BW'(HDR_BITS - 1)) begin
                     state <= READ;
                  end else if (bit_cnt == BW'(TOTAL_BITS - 1)) begin
                     state        <= CSOFF;
                     spi.SPI_CS_n <= 1'b1;
                     spi.MEM_VCC  <= 1'b0;
                     spi.SPI_MOSI <= 1'b0;
                  end
               end
            end
            CSOFF: state <= TX;
            TX: begin
               // pop is held off for one cycle so the UART busy flag can catch up
               if (!fifo_empty && !uart_busy && !pop)
                  pop <= 1'b1;
               else if (fifo_empty && !uart_busy && !pop)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign FIFO_TRIG_WR = push;
   assign FIFO_TRIG_DL = pop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (CLKA),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (rx_sh),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty)
   );

   uart_tx #(
      .UART_DIV (UART_DIV)
   ) u_uart (
      .clk   (CLKA),
      .rst   (rst),
      .start (pop),
      .data  (fifo_rd_data),
      .busy  (uart_busy),
      .tx    (UART_TX)
   );
endmodule

// File: tb/tb_fpga_top.sv
// tb/tb_fpga_top.sv - scoreboard bench for fpga_top with an SPI memory model and UART decoder
`timescale 1ns/1ps
module tb_fpga_top;
   localparam int SPI_HALF    = 2;
   localparam int UART_DIV    = 20;
   localparam int PWRUP_CYC   = 200;
   localparam int DEBOUNCE    = 4;
   localparam int READ_BYTES  = 16;
   localparam int FIFO_DEPTH  = 16;
   localparam int HDR_BITS    = 32;
   localparam int TOTAL_RISES = HDR_BITS + READ_BYTES * 8;

   typedef struct {
      logic [31:0] hdr;
      int          rises;
      int          wr;
   } spi_exp_t;

   logic CLKA = 1'b0;
   logic rst = 1'b0;
   logic pb_sw1 = 1'b1;
   logic UART_RX = 1'b1;
   logic miso = 1'b0;
   logic UART_TX;
   logic FIFO_TRIG_WR;
   logic FIFO_TRIG_DL;

   fpga_top_if spi_bus();
   assign spi_bus.SPI_MISO = miso;

   fpga_top #(
      .SPI_HALF   (SPI_HALF),
      .UART_DIV   (UART_DIV),
      .PWRUP_CYC  (PWRUP_CYC),
      .DEBOUNCE   (DEBOUNCE),
      .READ_BYTES (READ_BYTES),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .CLKA         (CLKA),
      .rst          (rst),
      .pb_sw1       (pb_sw1),
      .spi          (spi_bus),
      .UART_RX      (UART_RX),
      .UART_TX      (UART_TX),
      .FIFO_TRIG_WR (FIFO_TRIG_WR),
      .FIFO_TRIG_DL (FIFO_TRIG_DL)
   );

   always #25 CLKA = ~CLKA;

   int checks = 0;
   int failures = 0;
   int uart_bytes = 0;
   int dl_total = 0;
   int wr_total = 0;
   int tx_low_cnt = 0;
   int spi_rises = 0;
   int spi_rise_total = 0;
   bit abort_run = 1'b0;

   logic [7:0]  mem_data [READ_BYTES];
   logic [7:0]  uart_exp_q [$];
   spi_exp_t    spi_exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge CLKA) begin
      if (FIFO_TRIG_WR === 1'b1) wr_total++;
      if (FIFO_TRIG_DL === 1'b1) dl_total++;
      if (UART_TX === 1'b0) tx_low_cnt++;
   end

   always @(posedge spi_bus.SPI_CLK) spi_rise_total++;

   // Memory model: data byte k of the read lives at address k, MSB first
   always @(negedge spi_bus.SPI_CLK) begin
      int j;
      logic [7:0] b;
      j = spi_rises - HDR_BITS;
      if (j >= 0 && j < READ_BYTES * 8) begin
         b = mem_data[j / 8];
         miso = b[7 - (j % 8)];
      end else begin
         miso = 1'b0;
      end
   end

   logic [31:0] mon_hdr;
   int          mon_rd_ones;
   int          mon_wr0;
   spi_exp_t    mon_e;

   initial forever begin
      @(negedge spi_bus.SPI_CS_n);
      spi_rises   = 0;
      mon_hdr     = '0;
      mon_rd_ones = 0;
      mon_wr0     = wr_total;
      while (spi_bus.SPI_CS_n === 1'b0) begin
         @(posedge spi_bus.SPI_CLK or posedge spi_bus.SPI_CS_n);
         if (spi_bus.SPI_CS_n === 1'b0) begin
            spi_rises++;
            if (spi_rises <= HDR_BITS)
               mon_hdr = {mon_hdr[30:0], spi_bus.SPI_MOSI};
            else if (spi_bus.SPI_MOSI !== 1'b0)
               mon_rd_ones++;
         end
      end
      if (!abort_run) begin
         chk("spi_exp_q_nonempty", spi_exp_q.size() != 0, 1);
         if (spi_exp_q.size() != 0) begin
            mon_e = spi_exp_q.pop_front();
            chk("spi_cmd_addr_bits", mon_hdr, mon_e.hdr);
            chk("spi_clock_count", spi_rises, mon_e.rises);
            chk("spi_mosi_zero_in_read", mon_rd_ones, 0);
            chk("fifo_wr_pulses", wr_total - mon_wr0, mon_e.wr);
         end
      end
   end

   logic [7:0] rx_byte;
   logic [7:0] rx_exp;

   initial forever begin
      @(negedge UART_TX);
      chk("dl_pulse_before_start", dl_total, uart_bytes + 1);
      repeat (UART_DIV / 2) @(negedge CLKA);
      chk("uart_start_bit", UART_TX, 0);
      for (int i = 0; i < 8; i++) begin
         repeat (UART_DIV) @(negedge CLKA);
         rx_byte[i] = UART_TX;
      end
      repeat (UART_DIV) @(negedge CLKA);
      chk("uart_stop_bit", UART_TX, 1);
      uart_bytes++;
      chk("uart_exp_q_nonempty", uart_exp_q.size() != 0, 1);
      if (uart_exp_q.size() != 0) begin
         rx_exp = uart_exp_q.pop_front();
         chk("uart_byte", rx_byte, rx_exp);
      end
   end

   task automatic do_run(input int kind, input bit second_press);
      int lat, cyc, b0, d0, w;
      for (int i = 0; i < READ_BYTES; i++) begin
         if (kind == 0)      mem_data[i] = 8'h00;
         else if (kind == 1) mem_data[i] = (i % 2 == 0) ? 8'hA5 : 8'h3C;
         else                mem_data[i] = 8'($urandom_range(0, 255));
         uart_exp_q.push_back(mem_data[i]);
      end
      spi_exp_q.push_back('{32'h0300_0000, TOTAL_RISES, READ_BYTES});
      b0 = uart_bytes;
      d0 = dl_total;
      @(negedge CLKA);
      pb_sw1 = 1'b0;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge CLKA);
         if (lat == 0 && spi_bus.MEM_VCC === 1'b1) lat = i;
      end
      pb_sw1 = 1'b1;
      chk("vcc_latency_in_range", (lat >= 1 && lat <= DEBOUNCE + 3), 1);
      cyc = 8;
      while (spi_bus.SPI_CS_n !== 1'b0 && cyc < lat + PWRUP_CYC + 50) begin
         @(negedge CLKA);
         cyc++;
      end
      chk("cs_low_after_pwrup", cyc - lat, PWRUP_CYC);
      if (second_press) begin
         w = 0;
         while (uart_bytes == b0 && w < 5000) begin
            @(negedge CLKA);
            w++;
         end
         chk("first_byte_before_second_press", uart_bytes > b0, 1);
         pb_sw1 = 1'b0;
         repeat (8) @(negedge CLKA);
         pb_sw1 = 1'b1;
      end
      w = 0;
      while ((uart_exp_q.size() != 0 || spi_exp_q.size() != 0) && w < 8000) begin
         @(negedge CLKA);
         w++;
      end
      chk("run_completed", uart_exp_q.size() + spi_exp_q.size(), 0);
      repeat (300) @(negedge CLKA);
      chk("bytes_per_run", uart_bytes - b0, READ_BYTES);
      chk("dl_pulses_per_run", dl_total - d0, READ_BYTES);
      chk("vcc_off_after_run", spi_bus.MEM_VCC, 0);
      chk("cs_high_after_run", spi_bus.SPI_CS_n, 1);
   endtask

   initial begin
      int r0, t0, b0, w0, w;
      bit vcc_seen;
      rst = 1'b1;
      repeat (3) @(negedge CLKA);
      chk("rst_mem_vcc", spi_bus.MEM_VCC, 0);
      chk("rst_spi_clk", spi_bus.SPI_CLK, 0);
      chk("rst_spi_mosi", spi_bus.SPI_MOSI, 0);
      chk("rst_spi_cs_n", spi_bus.SPI_CS_n, 1);
      chk("rst_uart_tx", UART_TX, 1);
      chk("rst_trig_wr", FIFO_TRIG_WR, 0);
      chk("rst_trig_dl", FIFO_TRIG_DL, 0);
      rst = 1'b0;

      r0 = spi_rise_total;
      t0 = tx_low_cnt;
      repeat (800) @(negedge CLKA);
      chk("idle_no_sclk", spi_rise_total - r0, 0);
      chk("idle_tx_high", tx_low_cnt - t0, 0);
      chk("idle_vcc_off", spi_bus.MEM_VCC, 0);

      do_run(0, 1'b0);
      do_run(1, 1'b0);
      do_run(2, 1'b1);
      do_run(2, 1'b0);

      @(negedge CLKA);
      pb_sw1 = 1'b0;
      repeat (2) @(negedge CLKA);
      pb_sw1 = 1'b1;
      vcc_seen = 1'b0;
      repeat (40) begin
         @(negedge CLKA);
         if (spi_bus.MEM_VCC !== 1'b0) vcc_seen = 1'b1;
      end
      chk("glitch_ignored", vcc_seen, 0);

      abort_run = 1'b1;
      for (int i = 0; i < READ_BYTES; i++) mem_data[i] = 8'($urandom_range(0, 255));
      b0 = uart_bytes;
      w0 = wr_total;
      pb_sw1 = 1'b0;
      repeat (8) @(negedge CLKA);
      pb_sw1 = 1'b1;
      w = 0;
      while (wr_total - w0 < 5 && w < 2000) begin
         @(negedge CLKA);
         w++;
      end
      chk("abort_reached_read", wr_total - w0 >= 5, 1);
      rst = 1'b1;
      @(negedge CLKA);
      chk("abort_cs_n", spi_bus.SPI_CS_n, 1);
      chk("abort_mem_vcc", spi_bus.MEM_VCC, 0);
      chk("abort_spi_clk", spi_bus.SPI_CLK, 0);
      chk("abort_uart_tx", UART_TX, 1);
      rst = 1'b0;
      repeat (4000) @(negedge CLKA);
      chk("abort_no_uart", uart_bytes - b0, 0);
      chk("abort_vcc_stays_off", spi_bus.MEM_VCC, 0);
      abort_run = 1'b0;

      do_run(2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
